rom_dl_sequencer: RTL and testbench

- Sits between the HPS ioctl download interface and the ROM chip-select decoder / EPROM and PROM dual-port RAMs of the Tutankham core.
- Registers the ioctl byte stream and checks it: sequential addressing, ROM-index filtering and total size.
- Produces clean download write strobes, a running checksum and status.
- Holds the core in reset until a complete image has landed, then releases it after a settle delay.

---
 rtl/tut_dl_pkg.sv | 55 +++++
 rtl/dl_edge_det.sv | 32 +++
 rtl/rom_dl_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tut_dl_pkg.sv
// -----------------------------------------------------------------------------
// tut_dl_pkg
// Shared definitions for the Tutankham ROM download path.
//   dl_state_t       : download sequencer states.
//   *_BASE           : byte offsets of the LUT/PROM regions inside the image
//                      (the EPROM images occupy everything below TILE_LUT_BASE).
//   DEFAULT_ROM_SIZE : full image length (EPROMs + tile LUT + sprite LUT +
//                      colour PROM).
//   region_of()      : maps an image byte address to the region it lands in.
//   checksum_add()   : one step of the mod-2^16 running byte sum.
// -----------------------------------------------------------------------------
package tut_dl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        HOLD,
        DONE,
        ERROR
    } dl_state_t;

    localparam logic [24:0] TILE_LUT_BASE    = 25'h17000;
    localparam logic [24:0] SPRITE_LUT_BASE  = 25'h17100;
    localparam logic [24:0] COLOR_PROM_BASE  = 25'h17200;
    localparam logic [24:0] COLOR_PROM_BYTES = 25'h00020;
    localparam logic [24:0] DEFAULT_ROM_SIZE = COLOR_PROM_BASE + COLOR_PROM_BYTES;

    typedef enum logic [1:0] {
        REGION_EPROM,
        REGION_TILE_LUT,
        REGION_SPRITE_LUT,
        REGION_COLOR_PROM
    } rom_region_t;

    function automatic rom_region_t region_of(input logic [24:0] addr);
        rom_region_t region;
        if (addr >= COLOR_PROM_BASE) begin
            region = REGION_COLOR_PROM;
        end else if (addr >= SPRITE_LUT_BASE) begin
            region = REGION_SPRITE_LUT;
        end else if (addr >= TILE_LUT_BASE) begin
            region = REGION_TILE_LUT;
        end else begin
            region = REGION_EPROM;
        end
        return region;
    endfunction

    function automatic logic [15:0] checksum_add(input logic [15:0] sum,
                                                 input logic [7:0]  data);
        return sum + {8'h00, data};
    endfunction

endpackage

// File: rtl/dl_edge_det.sv
// -----------------------------------------------------------------------------
// dl_edge_det
// One-bit edge detector. The input is compared against its own registered
// copy, so rise/fall are valid in the same cycle the new level appears.
//   clk   : clock
//   rst_n : asynchronous active-low reset (registered copy clears to 0)
//   din   : level to watch
//   rise  : din is 1 now and was 0 last cycle
//   fall  : din is 0 now and was 1 last cycle
// -----------------------------------------------------------------------------
module dl_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_reg <= 1'b0;
        end else begin
            din_reg <= din;
        end
    end

    assign rise = din & ~din_reg;
    assign fall = ~din & din_reg;

endmodule

// File: rtl/rom_dl_sequencer.sv
// -----------------------------------------------------------------------------
// rom_dl_sequencer
// Registers the HPS ioctl byte stream for the ROM image, checks it (sequential
// addressing, index filtering, total length), produces clean RAM write strobes
// and a running checksum, and keeps the core in reset until a complete image
// has landed plus a settle delay.
//   CLK_DL         : download/system clock
//   RESET_N        : asynchronous active-low reset
//   ioctl_download : HPS transfer active
//   ioctl_index    : file index of the transfer (only ROM_INDEX is used)
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address of ioctl_dout
//   ioctl_dout     : byte data
//   dl_wr          : registered one-cycle write strobe to the RAM decode
//   dl_addr        : registered write address (passed through unmodified)
//   dl_data        : registered write data
//   core_reset     : active-high reset to CPUs and video
//   rom_ready      : image complete and valid
//   load_error     : sticky short/long/non-sequential image flag
//   byte_count     : bytes accepted in the current load (saturates at ROM_SIZE)
//   checksum       : mod-2^16 sum of accepted bytes
// -----------------------------------------------------------------------------
module rom_dl_sequencer
    import tut_dl_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX   = 8'h00,
    parameter logic [24:0] ROM_SIZE    = DEFAULT_ROM_SIZE,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        CLK_DL,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        dl_wr,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        load_error,
    output logic [24:0] byte_count,
    output logic [15:0] checksum
);

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    dl_state_t   state_reg, state_next;
    logic [15:0] hold_cnt_reg, hold_cnt_next;
    logic        dl_wr_reg, dl_wr_next;
    logic [24:0] dl_addr_reg, dl_addr_next;
    logic [7:0]  dl_data_reg, dl_data_next;
    logic [24:0] byte_count_reg, byte_count_next;
    logic [15:0] checksum_reg, checksum_next;
    logic        load_error_reg, load_error_next;
    logic        core_reset_reg;
    logic        rom_ready_reg;

    logic        active;
    logic        active_rise;
    logic        active_fall;

    // A transfer with any other index never qualifies, so it cannot disturb
    // the sequencer at all.
    assign active = ioctl_download && (ioctl_index == ROM_INDEX);

    dl_edge_det u_active_edge (
        .clk   (CLK_DL),
        .rst_n (RESET_N),
        .din   (active),
        .rise  (active_rise),
        .fall  (active_fall)
    );

    always_comb begin
        state_next      = state_reg;
        hold_cnt_next   = hold_cnt_reg;
        dl_wr_next      = 1'b0;
        dl_addr_next    = dl_addr_reg;
        dl_data_next    = dl_data_reg;
        byte_count_next = byte_count_reg;
        checksum_next   = checksum_reg;
        load_error_next = load_error_reg;

        if (active_rise && (state_reg != LOAD)) begin
            // A new image restarts from any non-loading state.
            state_next      = LOAD;
            byte_count_next = '0;
            checksum_next   = '0;
            load_error_next = 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    // Writes are honoured even on the cycle active falls, since
                    // the last byte can share a cycle with download dropping.
                    if (ioctl_wr) begin
                        if (byte_count_reg < ROM_SIZE) begin
                            dl_wr_next      = 1'b1;
                            dl_addr_next    = ioctl_addr;
                            dl_data_next    = ioctl_dout;
                            byte_count_next = byte_count_reg + 25'd1;
                            checksum_next   = checksum_add(checksum_reg, ioctl_dout);
                            if (ioctl_addr != byte_count_reg) begin
                                load_error_next = 1'b1;
                            end
                        end else begin
                            // Overlong image: drop the byte, flag it.
                            load_error_next = 1'b1;
                        end
                    end
                    if (active_fall) begin
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    if ((byte_count_reg == ROM_SIZE) && !load_error_reg) begin
                        state_next    = HOLD;
                        hold_cnt_next = HOLD_LOAD;
                    end else begin
                        state_next      = ERROR;
                        load_error_next = 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == 16'd0) begin
                        state_next = DONE;
                    end else begin
                        hold_cnt_next = hold_cnt_reg - 16'd1;
                    end
                end
                IDLE, DONE, ERROR: begin
                    state_next = state_reg;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= '0;
            dl_wr_reg      <= 1'b0;
            dl_addr_reg    <= '0;
            dl_data_reg    <= '0;
            byte_count_reg <= '0;
            checksum_reg   <= '0;
            load_error_reg <= 1'b0;
            core_reset_reg <= 1'b1;
            rom_ready_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            dl_wr_reg      <= dl_wr_next;
            dl_addr_reg    <= dl_addr_next;
            dl_data_reg    <= dl_data_next;
            byte_count_reg <= byte_count_next;
            checksum_reg   <= checksum_next;
            load_error_reg <= load_error_next;
            // Status follows the next state so core_reset goes high on the
            // very edge a new load is detected, ahead of the first dl_wr.
            core_reset_reg <= (state_next != DONE);
            rom_ready_reg  <= (state_next == DONE);
        end
    end

    assign dl_wr      = dl_wr_reg;
    assign dl_addr    = dl_addr_reg;
    assign dl_data    = dl_data_reg;
    assign byte_count = byte_count_reg;
    assign checksum   = checksum_reg;
    assign load_error = load_error_reg;
    assign core_reset = core_reset_reg;
    assign rom_ready  = rom_ready_reg;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rom_dl_sequencer
// Randomised download scenarios against a transaction-level model of the
// sequencer. The image size is scaled down to keep run time short; region
// behaviour does not depend on the absolute size.
// -----------------------------------------------------------------------------
module tb_rom_dl_sequencer;

    localparam int          RS  = 32'h220;
    localparam int          HC  = 4;
    localparam logic [7:0]  IDX = 8'h00;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        core_reset;
    logic        rom_ready;
    logic        load_error;
    logic [24:0] byte_count;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    rom_dl_sequencer #(
        .ROM_INDEX   (IDX),
        .ROM_SIZE    (25'(RS)),
        .HOLD_CYCLES (HC)
    ) dut (
        .CLK_DL         (clk),
        .RESET_N        (RESET_N),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .core_reset     (core_reset),
        .rom_ready      (rom_ready),
        .load_error     (load_error),
        .byte_count     (byte_count),
        .checksum       (checksum)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: what the DUT must show one edge after the current drive cycle.
    int          m_count = 0;
    logic [15:0] m_sum   = '0;
    bit          m_err   = 1'b0;
    bit          cur_wr  = 1'b0;
    logic [24:0] cur_addr = '0;
    logic [7:0]  cur_data = '0;
    bit          chk_en  = 1'b0;

    bit          p_wr    = 1'b0;
    logic [24:0] p_addr  = '0;
    logic [7:0]  p_data  = '0;
    int          p_count = 0;
    logic [15:0] p_sum   = '0;
    bit          p_err   = 1'b0;
    int          pulse_cnt = 0;

    // Per-cycle comparison: the expectation captured at the previous falling
    // edge is what the DUT must present one clock later.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dl_wr", 32'(dl_wr), 32'(p_wr));
            if (p_wr) begin
                check("dl_addr", 32'(dl_addr), 32'(p_addr));
                check("dl_data", 32'(dl_data), 32'(p_data));
            end
            check("byte_count", 32'(byte_count), 32'(p_count));
            check("checksum", 32'(checksum), 32'(p_sum));
            check("load_error", 32'(load_error), 32'(p_err));
        end
        if (dl_wr === 1'b1) pulse_cnt <= pulse_cnt + 1;
        p_wr    <= cur_wr;
        p_addr  <= cur_addr;
        p_data  <= cur_data;
        p_count <= m_count;
        p_sum   <= m_sum;
        p_err   <= m_err;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [24:0] a, input logic [7:0] d, input bit fall_now);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (fall_now) ioctl_download = 1'b0;
        if (m_count < RS) begin
            if (int'(a) != m_count) m_err = 1'b1;
            cur_wr   = 1'b1;
            cur_addr = a;
            cur_data = d;
            m_count++;
            m_sum = m_sum + 16'(d);
        end else begin
            m_err  = 1'b1;
            cur_wr = 1'b0;
        end
        step();
        ioctl_wr = 1'b0;
        cur_wr   = 1'b0;
    endtask

    task automatic start_load(input string tag);
        ioctl_index    = IDX;
        ioctl_download = 1'b1;
        m_count = 0;
        m_sum   = '0;
        m_err   = 1'b0;
        cur_wr  = 1'b0;
        step();
        #2;
        check({tag, ":core_reset_on_rise"}, 32'(core_reset), 32'd1);
        check({tag, ":rom_ready_on_rise"}, 32'(rom_ready), 32'd0);
    endtask

    task automatic run_load(input string tag, input int nbytes, input int skip_at,
                            input bit rnd_data, input int max_gap, input bit last_on_fall,
                            output int pulses);
        int          base;
        logic [24:0] a;
        logic [7:0]  d;
        bit          good;
        base = pulse_cnt;
        start_load(tag);
        for (int i = 0; i < nbytes; i++) begin
            repeat ($urandom_range(32'(max_gap), 0)) step();
            a = (skip_at >= 0 && i > skip_at) ? 25'(i + 1) : 25'(i);
            d = rnd_data ? 8'($urandom) : a[7:0];
            drive_write(a, d, last_on_fall && (i == nbytes - 1));
        end
        if (!last_on_fall) begin
            ioctl_download = 1'b0;
            step();
        end
        // The fall edge has just been taken.
        good = (m_count == RS) && !m_err;
        if (!good) m_err = 1'b1;
        if (good) begin
            repeat (HC + 1) begin
                @(negedge clk);
                check({tag, ":hold_core_reset"}, 32'(core_reset), 32'd1);
                check({tag, ":hold_rom_ready"}, 32'(rom_ready), 32'd0);
            end
            @(negedge clk);
            check({tag, ":done_core_reset"}, 32'(core_reset), 32'd0);
            check({tag, ":done_rom_ready"}, 32'(rom_ready), 32'd1);
        end else begin
            repeat (2) @(negedge clk);
            check({tag, ":err_core_reset"}, 32'(core_reset), 32'd1);
            check({tag, ":err_rom_ready"}, 32'(rom_ready), 32'd0);
            check({tag, ":err_load_error"}, 32'(load_error), 32'd1);
            repeat (HC + 2) @(negedge clk);
            check({tag, ":err_stays_reset"}, 32'(core_reset), 32'd1);
            check({tag, ":err_stays_not_ready"}, 32'(rom_ready), 32'd0);
        end
        step();
        pulses = pulse_cnt - base;
        $display("load %s: sent=%0d count=0x%0h checksum=0x%04h err=%0b ready=%0b pulses=%0d",
                 tag, nbytes, byte_count, checksum, load_error, rom_ready, pulses);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "time limit reached");
    end

    initial begin
        int pulses;
        int base;

        RESET_N = 1'b1;
        #2 RESET_N = 1'b0;
        #2;
        check("reset:dl_wr", 32'(dl_wr), 32'd0);
        check("reset:core_reset", 32'(core_reset), 32'd1);
        check("reset:rom_ready", 32'(rom_ready), 32'd0);
        check("reset:load_error", 32'(load_error), 32'd0);
        check("reset:byte_count", 32'(byte_count), 32'd0);
        check("reset:checksum", 32'(checksum), 32'd0);
        #18 RESET_N = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        #2;
        check("idle:core_reset", 32'(core_reset), 32'd1);
        $display("reset: core_reset=%0b rom_ready=%0b", core_reset, rom_ready);

        // Sequential good image, data = addr[7:0].
        run_load("good_seq", RS, -1, 1'b0, 0, 1'b0, pulses);
        check("good_seq:checksum_pin", 32'(checksum), 32'h00F0);
        check("good_seq:count_pin", 32'(byte_count), 32'h220);
        check("good_seq:pulses_pin", 32'(pulses), 32'h220);

        // Foreign index while DONE.
        base = pulse_cnt;
        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'($urandom);
            step();
            ioctl_wr = 1'b0;
            #2;
            check("foreign:rom_ready", 32'(rom_ready), 32'd1);
            check("foreign:core_reset", 32'(core_reset), 32'd0);
        end
        ioctl_download = 1'b0;
        step();
        ioctl_index = IDX;
        step();
        step();
        check("foreign:checksum_pin", 32'(checksum), 32'h00F0);
        check("foreign:pulses", 32'(pulse_cnt - base), 32'd0);
        $display("foreign: 16 bytes index 1, ready=%0b checksum=0x%04h", rom_ready, checksum);

        // Reload from DONE with random data, gaps, last byte on the fall.
        run_load("reload_rnd", RS, -1, 1'b1, 2, 1'b1, pulses);
        check("reload_rnd:pulses", 32'(pulses), 32'(RS));

        // Short image.
        run_load("short", 32'h200, -1, 1'b0, 0, 1'b0, pulses);
        check("short:count_pin", 32'(byte_count), 32'h200);
        check("short:checksum_pin", 32'(checksum), 32'hFF00);

        // Skipped address 0x0FF -> 0x101, full byte count still sent.
        run_load("skip", RS, 32'h0FF, 1'b0, 1, 1'b0, pulses);
        check("skip:load_error", 32'(load_error), 32'd1);
        check("skip:count", 32'(byte_count), 32'h220);

        // Overlong image.
        run_load("overlong", RS + 1, -1, 1'b0, 0, 1'b0, pulses);
        check("overlong:pulses_pin", 32'(pulses), 32'h220);
        check("overlong:count_pin", 32'(byte_count), 32'h220);
        check("overlong:load_error", 32'(load_error), 32'd1);

        // Recovery from ERROR.
        run_load("after_err", RS, -1, 1'b1, 2, 1'b0, pulses);
        check("after_err:rom_ready", 32'(rom_ready), 32'd1);

        // Reset pulsed mid-load.
        start_load("midreset");
        for (int i = 0; i < 40; i++) drive_write(25'(i), 8'($urandom), 1'b0);
        #2;
        RESET_N = 1'b0;
        chk_en  = 1'b0;
        #1;
        check("midreset:dl_wr", 32'(dl_wr), 32'd0);
        check("midreset:dl_addr", 32'(dl_addr), 32'd0);
        check("midreset:dl_data", 32'(dl_data), 32'd0);
        check("midreset:core_reset", 32'(core_reset), 32'd1);
        check("midreset:rom_ready", 32'(rom_ready), 32'd0);
        check("midreset:load_error", 32'(load_error), 32'd0);
        check("midreset:byte_count", 32'(byte_count), 32'd0);
        check("midreset:checksum", 32'(checksum), 32'd0);
        ioctl_download = 1'b0;
        m_count = 0;
        m_sum   = '0;
        m_err   = 1'b0;
        cur_wr  = 1'b0;
        repeat (2) step();
        RESET_N = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        #2;
        check("midreset:idle_core_reset", 32'(core_reset), 32'd1);
        check("midreset:idle_rom_ready", 32'(rom_ready), 32'd0);
        $display("midreset: outputs cleared, core_reset=%0b", core_reset);

        run_load("post_reset", RS, -1, 1'b1, 1, 1'b0, pulses);
        check("post_reset:rom_ready", 32'(rom_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
